// File: rtl/axi_txn_pkg.sv
// Shared definitions for the AXI transaction arbiter.
//   - Default parameter values (requester count, address width, WAIT timeout).
//   - FSM state encoding: IDLE, ISSUE, WAIT, CMPL.
//   - idx_width(): index width helper that never returns 0.
package axi_txn_pkg;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StCmpl  = 2'd3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
// Picks the lowest set request index at or above ptr_i, wrapping modulo NUM_REQ.
// Ports:
//   req_i     - request vector
//   ptr_i     - round-robin start pointer
//   gnt_oh_o  - one-hot winner (all zero when no request)
//   gnt_idx_o - winner index
//   valid_o   - at least one request present
module rr_select
  import axi_txn_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               valid_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        gnt_oh_o[cand]  = 1'b1;
        gnt_idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/axi_txn_arbiter.sv
// Round-robin arbiter sharing one AXI full master among NUM_REQ requesters.
// Optional WAIT timeout is compiled in with macro AXI_TXN_TIMEOUT_EN.
// Ports:
//   AXI_ACLK, AXI_ARESETN - clock, async active-low reset
//   REQ, REQ_ADDR         - level requests and per-requester base addresses
//   GNT, DONE, ERR        - one-cycle one-hot grant / completion / timeout pulses
//   INIT_AXI_TXN          - start pulse to the master
//   TXN_ADDR              - base address presented to the master
//   TXN_DONE              - master completion level
//   BUSY                  - high whenever the FSM is not idle
module axi_txn_arbiter
  import axi_txn_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESETN,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        DONE,
  output logic [NUM_REQ-1:0]        ERR,
  output logic                      INIT_AXI_TXN,
  output logic [ADDR_W-1:0]         TXN_ADDR,
  input  logic                      TXN_DONE,
  output logic                      BUSY
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    winner_q, winner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               init_q, init_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               txn_done_q, txn_done_prev_q;
  logic               arm_q;

  logic [NUM_REQ-1:0] sel_oh;
  logic [IdxW-1:0]    sel_idx;
  logic               sel_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [NUM_REQ-1:0] winner_oh;
  logic               txn_rise;
  logic               timeout;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_select (
    .req_i     (REQ),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (sel_oh),
    .gnt_idx_o (sel_idx),
    .valid_o   (sel_valid)
  );

  assign sel_addr = REQ_ADDR[32'(sel_idx) * ADDR_W +: ADDR_W];

  // TXN_DONE is registered once, then compared against its previous sample, so a level
  // left high by an earlier transaction never looks like a new completion.
  assign txn_rise = txn_done_q & ~txn_done_prev_q;

  always_comb begin
    winner_oh           = '0;
    winner_oh[winner_q] = 1'b1;
  end

`ifdef AXI_TXN_TIMEOUT_EN
  localparam int unsigned CntW = idx_width(TIMEOUT_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Zero in ISSUE, so the first WAIT cycle sees 0.
  assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    init_d   = 1'b0;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      StIdle: begin
        // arm_q holds off arbitration until the second edge after reset release.
        if (arm_q && sel_valid) begin
          state_d  = StIssue;
          winner_d = sel_idx;
          addr_d   = sel_addr;
          init_d   = 1'b1;
          gnt_d    = sel_oh;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (txn_rise) begin
          state_d = StCmpl;
          done_d  = winner_oh;
        end else if (timeout) begin
          state_d = StCmpl;
          err_d   = winner_oh;
        end
      end
      StCmpl: begin
        state_d = StIdle;
        ptr_d   = (winner_q == IdxW'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      winner_q        <= '0;
      addr_q          <= '0;
      init_q          <= 1'b0;
      busy_q          <= 1'b0;
      gnt_q           <= '0;
      done_q          <= '0;
      err_q           <= '0;
      txn_done_q      <= 1'b0;
      txn_done_prev_q <= 1'b0;
      arm_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      winner_q        <= winner_d;
      addr_q          <= addr_d;
      init_q          <= init_d;
      busy_q          <= busy_d;
      gnt_q           <= gnt_d;
      done_q          <= done_d;
      err_q           <= err_d;
      txn_done_q      <= TXN_DONE;
      txn_done_prev_q <= txn_done_q;
      arm_q           <= 1'b1;
    end
  end

  assign GNT          = gnt_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign INIT_AXI_TXN = init_q;
  assign TXN_ADDR     = addr_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Directed bench for axi_txn_arbiter (4 requesters, 32-bit addresses, TIMEOUT_CYC=16).
// Inputs are driven and outputs sampled on the falling clock edge.
// The timeout scenario is compiled only with AXI_TXN_TIMEOUT_EN.
module tb_axi_txn_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 16;
`ifdef AXI_TXN_TIMEOUT_EN
  localparam int unsigned SINGLE_DLY  = 8;
`else
  localparam int unsigned SINGLE_DLY  = 20;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        gnt, done, err;
  logic                      init_txn;
  logic [ADDR_W-1:0]         txn_addr;
  logic                      txn_done = 1'b0;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  int done_cnt = 0;
  logic [NUM_REQ-1:0] err_seen = '0;

  always #5 clk = ~clk;

  axi_txn_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .AXI_ACLK     (clk),
    .AXI_ARESETN  (rst_n),
    .REQ          (req),
    .REQ_ADDR     (req_addr),
    .GNT          (gnt),
    .DONE         (done),
    .ERR          (err),
    .INIT_AXI_TXN (init_txn),
    .TXN_ADDR     (txn_addr),
    .TXN_DONE     (txn_done),
    .BUSY         (busy)
  );

  always @(negedge clk) begin
    if (init_txn === 1'b1) init_cnt++;
    if (|done) done_cnt++;
    err_seen |= err;
  end

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the ISSUE cycle; current cycle is ISSUE on return if found.
  task automatic wait_issue(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (init_txn === 1'b1) ok = 1'b1;
    end
    check({tag, "_issue_seen"}, 64'(ok), 64'd1);
  endtask

  // One transaction: master raises TXN_DONE two cycles after ISSUE.
  task automatic run_txn(input string tag, input logic [NUM_REQ-1:0] exp_gnt, input int idx);
    wait_issue(tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    check({tag, "_addr"}, 64'(txn_addr), 64'(addr_of(idx)));
    txn_done = 1'b0;
    repeat (2) @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    check({tag, "_no_early_done"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(exp_gnt));
    check({tag, "_excl"}, 64'({gnt, err, init_txn}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);

    // Reset state; requester 1 already waiting.
    req = 4'b0010;
    repeat (3) @(negedge clk);
    check("rst_pulses", 64'({gnt, done, err, init_txn, busy}), 64'd0);
    check("rst_addr", 64'(txn_addr), 64'd0);

    // Single request: no arbitration on first edge after release.
    rst_n = 1'b1;
    @(negedge clk);
    check("arm_delay", 64'({gnt, init_txn, busy}), 64'd0);
    @(negedge clk);
    check("single_init", 64'(init_txn), 64'd1);
    check("single_gnt", 64'(gnt), 64'b0010);
    check("single_addr", 64'(txn_addr), 64'(addr_of(1)));
    check("single_busy", 64'(busy), 64'd1);
    @(negedge clk);
    req = 4'b0000;  // drop right after grant; transaction must still finish
    check("issue_one_cycle", 64'({gnt, init_txn}), 64'd0);
    repeat (SINGLE_DLY - 1) @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    check("single_no_early_done", 64'(done), 64'd0);
    @(negedge clk);
    check("single_done", 64'(done), 64'b0010);
    check("single_cmpl_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("single_idle", 64'({done, busy}), 64'd0);

    // Stale TXN_DONE level must not complete; PTR is now 2.
    req = 4'b0100;
    @(negedge clk);
    check("stale_gnt", 64'(gnt), 64'b0100);
    repeat (10) @(negedge clk);
    check("stale_no_done", 64'({done, busy}), 64'(5'b0000_1));
    txn_done = 1'b0;
    repeat (2) @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    check("stale_no_early_done", 64'(done), 64'd0);
    @(negedge clk);
    check("stale_done", 64'(done), 64'b0100);

    // PTR=3, only requester 0: wrap-around; then reset mid-WAIT.
    req = 4'b0001;
    @(negedge clk);
    check("wrap_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("wrap_gnt", 64'(gnt), 64'b0001);
    txn_done = 1'b0;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", 64'({gnt, done, err, init_txn, busy}), 64'd0);
    check("async_rst_addr", 64'(txn_addr), 64'd0);
    @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
    req = 4'b1111;
    rst_n = 1'b1;

    // All requesting continuously from PTR=0.
    run_txn("rr0", 4'b0001, 0);
    run_txn("rr1", 4'b0010, 1);
    run_txn("rr2", 4'b0100, 2);
    run_txn("rr3", 4'b1000, 3);
    run_txn("rr4", 4'b0001, 0);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("init_count", 64'(init_cnt), 64'd8);
    check("done_count", 64'(done_cnt), 64'd7);

`ifdef AXI_TXN_TIMEOUT_EN
    // PTR=1; TXN_DONE never rises.
    req = 4'b0010;
    wait_issue("tmo");
    check("tmo_gnt", 64'(gnt), 64'b0010);
    txn_done = 1'b0;
    req = 4'b0011;
    repeat (16) @(negedge clk);
    check("tmo_not_yet", 64'(err), 64'd0);
    @(negedge clk);
    check("tmo_err", 64'(err), 64'b0010);
    check("tmo_no_done", 64'(done), 64'd0);
    wait_issue("tmo_next");
    check("tmo_next_gnt", 64'(gnt), 64'b0001);
`else
    check("err_never", 64'(err_seen), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_txn_arbiter.md
AXI_TXN_ARBITER -- requirements
Module: axi_txn_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 32, width of the per-requester target base address.
REQ-003 Parameter TIMEOUT_CYC, default 4096, WAIT-state cycle limit (used only with timeout compiled in).
REQ-004 AXI_ACLK  in  1  single clock; all logic rising-edge.
REQ-005 AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 REQ  in  NUM_REQ  level request per requester; held until its GNT.
REQ-007 REQ_ADDR  in  NUM_REQ*ADDR_W  base address, slice i belongs to requester i.
REQ-008 GNT  out  NUM_REQ  one-cycle one-hot grant pulse.
REQ-009 DONE  out  NUM_REQ  one-cycle one-hot completion pulse to granted requester.
REQ-010 ERR  out  NUM_REQ  one-cycle one-hot timeout pulse (held 0 without timeout).
REQ-011 INIT_AXI_TXN  out  1  start pulse to shared AXI full master.
REQ-012 TXN_ADDR  out  ADDR_W  base address presented to master, stable from ISSUE until return to IDLE.
REQ-013 TXN_DONE  in  1  master completion flag (level, stays high until next start).
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, CMPL.
REQ-016 IDLE: if any REQ bit set at edge t, SHALL select winner, latch index and REQ_ADDR slice, enter ISSUE at t+1.
REQ-017 Arbitration SHALL be round-robin: lowest index >= pointer PTR among set REQ bits, wrapping modulo NUM_REQ.
REQ-018 ISSUE (exactly one cycle): INIT_AXI_TXN=1, GNT[winner]=1; next state WAIT.
REQ-019 WAIT: SHALL detect TXN_DONE rising edge (registered previous value 0, current 1); level-high TXN_DONE from a prior transaction SHALL NOT complete.
REQ-020 On detected edge SHALL enter CMPL; CMPL (one cycle) drives DONE[winner]=1, sets PTR=(winner+1) mod NUM_REQ, returns to IDLE.
REQ-021 Minimum spacing between successive INIT_AXI_TXN pulses SHALL be 4 cycles (ISSUE, WAIT>=1, CMPL, IDLE).
REQ-022 REQ changes during ISSUE/WAIT/CMPL SHALL be ignored; a requester deasserting after GNT does not abort the transaction.
REQ-023 REQ for current winner still high in IDLE after CMPL SHALL be re-arbitrated normally (no starvation of others due to PTR advance).
REQ-024 All outputs SHALL be registered; INIT_AXI_TXN, GNT, DONE, ERR never high in the same cycle as another pulse of a different phase.

Reset
REQ-025 AXI_ARESETN low SHALL immediately force state IDLE, PTR=0, INIT_AXI_TXN=0, GNT=0, DONE=0, ERR=0, BUSY=0, TXN_ADDR=0, TXN_DONE history=0.
REQ-026 Reset mid-WAIT SHALL drop the transaction silently (no DONE/ERR); master is reset by the same signal.
REQ-027 First arbitration after deassertion SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 Macro AXI_TXN_TIMEOUT_EN defined: WAIT counter counts from 0; reaching TIMEOUT_CYC-1 without TXN_DONE edge SHALL enter CMPL with ERR[winner]=1 instead of DONE, PTR advanced as normal.
REQ-029 Macro undefined: no counter logic, WAIT waits indefinitely, ERR tied 0.

Structure
REQ-030 Shared package axi_txn_pkg SHALL hold the state encoding constants and default ADDR_W/TIMEOUT_CYC.
REQ-031 Round-robin selector SHALL be sub-module rr_select (inputs REQ, PTR; outputs one-hot and index), combinational.

Verification
REQ-032 Single request: REQ=4'b0010, master asserts TXN_DONE 20 cycles after INIT -> GNT=0010 at ISSUE, DONE=0010 two cycles after TXN_DONE rise, TXN_ADDR=REQ_ADDR[1].
REQ-033 All four requesting continuously, PTR=0 -> grant order 0,1,2,3,0; exactly one INIT per transaction.
REQ-034 TXN_DONE left high from prior transaction -> no DONE until master drops and re-raises it.
REQ-035 With AXI_TXN_TIMEOUT_EN, TIMEOUT_CYC=16, TXN_DONE never rises -> ERR[winner] pulses 17 cycles after ISSUE, next requester granted.
REQ-036 AXI_ARESETN low mid-WAIT -> all outputs 0 within same cycle, no DONE/ERR, PTR=0 after release.
REQ-037 REQ deasserted the cycle after GNT -> transaction completes, DONE still pulses.
